// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and types for the interrupt controller
// Purpose: register map, FSM state encoding and default source count.
// Ports: none (package).
package irq_pkg;

  localparam int IRQC_N_SRC = 6;

  localparam logic [1:0] IRQC_MASK = 2'd0;
  localparam logic [1:0] IRQC_PEND = 2'd1;
  localparam logic [1:0] IRQC_ID   = 2'd2;
  localparam logic [1:0] IRQC_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - register bus between the bridge and the interrupt controller
// Purpose: groups the 2-bit-addressed register access signals.
// Ports (members):
//   Addr  [1:0]   register select
//   Wd    [31:0]  write data
//   We            write enable, one cycle per write
//   rd_en         read strobe from the bridge read decode
//   Rd    [31:0]  read data, combinational from Addr
interface irq_ctrl_if;

  logic [1:0]  Addr;
  logic [31:0] Wd;
  logic        We;
  logic        rd_en;
  logic [31:0] Rd;

  modport master (output Addr, output Wd, output We, output rd_en, input Rd);
  modport slave  (input Addr, input Wd, input We, input rd_en, output Rd);

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins priority encoder
// Purpose: picks the lowest set bit of req.
// Ports:
//   req  in  [N-1:0]  candidate requests (PEND & MASK)
//   any  out          at least one request present
//   id   out [3:0]    index of the winning request (0 when none)
module irq_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic         any,
  output logic [3:0]   id
);

  always_comb begin
    any = |req;
    id  = '0;
    // Scan downwards so the lowest set index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = 4'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller with mask, pending register and EOI handshake
// Purpose: latches device requests, applies a mask, presents one source at a
//   time to the CPU by fixed priority and holds it until end-of-interrupt.
// Build option: IRQC_EDGE_EN selects rising-edge capture; default is level capture.
// Ports:
//   Clk    in   system clock
//   Reset  in   synchronous, active-high reset
//   IrqIn  in   [N_SRC-1:0] raw device requests
//   bus    slave register port (Addr/Wd/We/rd_en/Rd)
//   HWInt  out  [N_SRC-1:0] one-hot request to the CPU, registered
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_SRC = IRQC_N_SRC
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_SRC-1:0] IrqIn,
  irq_ctrl_if.slave        bus,
  output logic [N_SRC-1:0] HWInt
);

  localparam logic [N_SRC-1:0] ONE = 1;

  irq_state_t       state;
  logic [3:0]       id;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] set_v;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] svc_clr;
  logic [N_SRC-1:0] id_oh;
  logic [N_SRC-1:0] win_oh;
  logic [N_SRC-1:0] req_v;
  logic             any;
  logic [3:0]       win_id;
  logic             wr_mask;
  logic             wr_eoi;
  logic             id_rd;
  logic             abort;
  logic             unused_wd;

  assign unused_wd = ^bus.Wd[31:N_SRC];

`ifdef IRQC_EDGE_EN
  logic [N_SRC-1:0] irq_d;
  always_ff @(posedge Clk) begin
    if (Reset) irq_d <= '0;
    else       irq_d <= irq_q;
  end
  assign set_v = irq_q & ~irq_d;
`else
  assign set_v = irq_q;
`endif

  assign req_v = pend & mask;

  irq_prio_enc #(.N(N_SRC)) u_prio_enc (
    .req (req_v),
    .any (any),
    .id  (win_id)
  );

  always_comb begin
    wr_mask = bus.We && (bus.Addr == IRQC_MASK);
    wr_eoi  = bus.We && (bus.Addr == IRQC_EOI);
    id_rd   = bus.rd_en && !bus.We && (bus.Addr == IRQC_ID);
    w1c     = (bus.We && (bus.Addr == IRQC_PEND)) ? bus.Wd[N_SRC-1:0] : '0;
    id_oh   = ONE << id;
    win_oh  = ONE << win_id;
    // Presented source lost its mask or its pending bit before the ID read.
    abort   = ((mask & id_oh) == '0) || ((pend & id_oh) == '0);
    svc_clr = (state == REQ && !abort && id_rd) ? id_oh : '0;
  end

  always_comb begin
    bus.Rd = '0;
    case (bus.Addr)
      IRQC_MASK: bus.Rd = 32'(mask);
      IRQC_PEND: bus.Rd = 32'(pend);
      IRQC_ID:   bus.Rd = {27'b0, (state != IDLE), id};
      default:   bus.Rd = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      id    <= '0;
      irq_q <= '0;
      pend  <= '0;
      mask  <= '0;
      HWInt <= '0;
    end else begin
      irq_q <= IrqIn;
      // New set beats a same-cycle clear, whether from W1C or service entry.
      pend  <= (pend & ~(w1c | svc_clr)) | set_v;
      if (wr_mask) mask <= bus.Wd[N_SRC-1:0];

      case (state)
        IDLE: begin
          HWInt <= '0;
          if (any) begin
            id    <= win_id;
            HWInt <= win_oh;
            state <= REQ;
          end
        end
        REQ: begin
          if (abort) begin
            HWInt <= '0;
            state <= IDLE;
          end else if (id_rd) begin
            HWInt <= '0;
            state <= SERVICE;
          end
        end
        SERVICE: begin
          HWInt <= '0;
          if (wr_eoi) state <= IDLE;
        end
        default: begin
          HWInt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;
  import irq_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  IrqIn;
  logic [5:0]  HWInt;
  irq_ctrl_if  bus ();

  irq_ctrl #(.N_SRC(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .IrqIn (IrqIn),
    .bus   (bus),
    .HWInt (HWInt)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.Addr  = a;
    bus.Wd    = d;
    bus.We    = 1'b1;
    bus.rd_en = 1'b0;
    tick();
    bus.We    = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    bus.Addr  = a;
    bus.We    = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    d = bus.Rd;
  endtask

  task automatic read_id(output logic [31:0] d);
    bus.Addr  = IRQC_ID;
    bus.We    = 1'b0;
    bus.rd_en = 1'b1;
    #1;
    d = bus.Rd;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_hwint(output logic [5:0] v, output int n);
    n = 0;
    while (HWInt == 6'b0 && n < 20) begin
      tick();
      n++;
    end
    v = HWInt;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    Reset = 1'b1;
    IrqIn = '0;
    bus.Addr = '0; bus.Wd = '0; bus.We = 1'b0; bus.rd_en = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL reset_hwint got %h want 00", HWInt); end
    peek(IRQC_MASK, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", d); end
    peek(IRQC_PEND, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_pend got %h want 0", d); end
    peek(IRQC_ID, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_id got %h want 0", d); end
  endtask

  task automatic test_basic;
    logic [31:0] d, exp;
    bus_write(IRQC_MASK, 32'h3);
    IrqIn = 6'b000010;
    sb.push_back(32'h02);
    tick();
    IrqIn = '0;
    tick();
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL basic_early got %h want 00", HWInt); end
    tick();
    exp = sb.pop_front();
    checks++;
    if (32'(HWInt) !== exp) begin errors++; $display("FAIL basic_latency got %h want %h", HWInt, exp); end
    sb.push_back(32'h11);
    read_id(d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL basic_id got %h want %h", d, exp); end
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL basic_drop got %h want 00", HWInt); end
    peek(IRQC_PEND, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL basic_pend_clr got %h want 0", d); end
    bus_write(IRQC_EOI, 32'h0);
    peek(IRQC_ID, d);
    checks++;
    if (d[4] !== 1'b0) begin errors++; $display("FAIL basic_eoi_valid got %b want 0", d[4]); end
  endtask

  task automatic test_priority;
    logic [31:0] d, exp;
    logic [5:0]  v;
    int          n;
    bus_write(IRQC_MASK, 32'h3F);
    IrqIn = 6'b000011;
    sb.push_back(32'h01);
    tick();
    IrqIn = '0;
    wait_hwint(v, n);
    exp = sb.pop_front();
    checks++;
    if (32'(v) !== exp) begin errors++; $display("FAIL prio_first got %h want %h (cycles %0d)", v, exp, n); end
    sb.push_back(32'h10);
    read_id(d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL prio_id0 got %h want %h", d, exp); end
    sb.push_back(32'h02);
    bus_write(IRQC_EOI, 32'h0);
    wait_hwint(v, n);
    exp = sb.pop_front();
    checks++;
    if (32'(v) !== exp) begin errors++; $display("FAIL prio_second got %h want %h (cycles %0d)", v, exp, n); end
    read_id(d);
    bus_write(IRQC_EOI, 32'h0);
  endtask

  task automatic test_mask_gate;
    logic [31:0] d, exp;
    bus_write(IRQC_MASK, 32'h0);
    IrqIn = 6'b000100;
    tick(); tick(); tick();
    sb.push_back(32'h04);
    peek(IRQC_PEND, d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL gate_pend got %h want %h", d, exp); end
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL gate_masked got %h want 00", HWInt); end
    IrqIn = '0;
    tick();
    bus_write(IRQC_MASK, 32'h04);
    sb.push_back(32'h04);
    tick();
    exp = sb.pop_front();
    checks++;
    if (32'(HWInt) !== exp) begin errors++; $display("FAIL gate_unmask got %h want %h", HWInt, exp); end
    read_id(d);
    bus_write(IRQC_EOI, 32'h0);
  endtask

  task automatic test_mask_abort;
    logic [31:0] d, exp;
    logic [5:0]  v;
    int          n;
    bus_write(IRQC_MASK, 32'h3F);
    IrqIn = 6'b000010;
    sb.push_back(32'h02);
    tick();
    IrqIn = '0;
    wait_hwint(v, n);
    exp = sb.pop_front();
    checks++;
    if (32'(v) !== exp) begin errors++; $display("FAIL abort_req got %h want %h (cycles %0d)", v, exp, n); end
    bus_write(IRQC_MASK, 32'h0);
    tick();
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL abort_hwint got %h want 00", HWInt); end
    peek(IRQC_ID, d);
    checks++;
    if (d[4] !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", d[4]); end
    sb.push_back(32'h02);
    peek(IRQC_PEND, d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL abort_pend got %h want %h", d, exp); end
    bus_write(IRQC_PEND, 32'h02);
  endtask

  task automatic test_w1c_race;
    logic [31:0] d, exp;
    bus_write(IRQC_MASK, 32'h0);
    IrqIn = 6'b001000;
    tick();
    // W1C lands on the same edge the new edge sets PEND[3].
    bus_write(IRQC_PEND, 32'h08);
    sb.push_back(32'h08);
    peek(IRQC_PEND, d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL race_set_wins got %h want %h", d, exp); end
    bus_write(IRQC_PEND, 32'h08);
    tick();
`ifdef IRQC_EDGE_EN
    sb.push_back(32'h00);
`else
    sb.push_back(32'h08);
`endif
    peek(IRQC_PEND, d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL race_held got %h want %h", d, exp); end
    IrqIn = '0;
    tick(); tick();
    bus_write(IRQC_PEND, 32'h08);
    peek(IRQC_PEND, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL race_cleared got %h want 0", d); end
  endtask

  task automatic test_reset_in_service;
    logic [31:0] d, exp;
    logic [5:0]  v;
    int          n;
    bus_write(IRQC_MASK, 32'h3F);
    IrqIn = 6'b000101;
    sb.push_back(32'h01);
    tick();
    IrqIn = '0;
    wait_hwint(v, n);
    exp = sb.pop_front();
    checks++;
    if (32'(v) !== exp) begin errors++; $display("FAIL rst_req got %h want %h (cycles %0d)", v, exp, n); end
    sb.push_back(32'h10);
    read_id(d);
    exp = sb.pop_front();
    checks++;
    if (d !== exp) begin errors++; $display("FAIL rst_svc_id got %h want %h", d, exp); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL rst_hwint got %h want 00", HWInt); end
    peek(IRQC_PEND, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_pend got %h want 0", d); end
    peek(IRQC_MASK, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_mask got %h want 0", d); end
    peek(IRQC_ID, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_id got %h want 0", d); end
    bus_write(IRQC_EOI, 32'h0);
    tick();
    peek(IRQC_ID, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_eoi_ignored got %h want 0", d); end
    checks++;
    if (HWInt !== 6'b0) begin errors++; $display("FAIL rst_eoi_hwint got %h want 00", HWInt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask_gate();
    test_mask_abort();
    test_w1c_race();
    test_reset_in_service();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
